// File: rtl/spi_relay_pkg.sv
// spi_relay_pkg: shared encodings, FSM state types and the frame transform.
package spi_relay_pkg;

  // Widest frame the transform function can handle; callers size-cast in and out.
  localparam int unsigned XFORM_W = 512;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_INV   = 2'd1,
    MODE_INC   = 2'd2,
    MODE_BSWAP = 2'd3
  } mode_e;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_STROBE = 2'd1,
    TX_GUARD  = 2'd2
  } tx_state_e;

  // Applies the MODE transform to the low data_w bits of data. Bits above data_w
  // in the result are don't-care; the caller truncates them, which also makes
  // MODE_INC wrap all-ones to zero.
  function automatic logic [XFORM_W-1:0] transform(input mode_e                mode,
                                                    input logic [XFORM_W-1:0] data,
                                                    input int unsigned        data_w);
    logic [XFORM_W-1:0] res;
    int                 nbytes;
    nbytes = int'(data_w / 8);
    res    = data;
    case (mode)
      MODE_PASS: res = data;
      MODE_INV:  res = ~data;
      MODE_INC:  res = data + {{(XFORM_W - 1){1'b0}}, 1'b1};
      MODE_BSWAP: begin
        res = '0;
        for (int i = 0; i < int'(XFORM_W / 8); i++) begin
          if (i < nbytes) begin
            res[8*i +: 8] = data[8*(nbytes-1-i) +: 8];
          end
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/spi_frame_relay_if.sv
// spi_frame_relay_if: handshake, control and statistics signals of the frame relay.
interface spi_frame_relay_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_rd;
  logic              tx_busy;
  logic              tx_wr;
  logic [DATA_W-1:0] tx_data;
  logic              enable;
  logic [1:0]        mode;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  rx_cnt;
  logic [CNT_W-1:0]  tx_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  // Relay side
  modport slave (
    input  rx_valid, rx_data, tx_busy, enable, mode,
    output rx_rd, tx_wr, tx_data, level, rx_cnt, tx_cnt, drop_cnt
  );

  // Driver side (slave/master cores or a bench)
  modport master (
    output rx_valid, rx_data, tx_busy, enable, mode,
    input  rx_rd, tx_wr, tx_data, level, rx_cnt, tx_cnt, drop_cnt
  );

endinterface

// File: rtl/spi_relay_fifo.sv
// spi_relay_fifo: synchronous FIFO with registered level; push ignored when full,
// pop ignored when empty.
module spi_relay_fifo #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_head,
  output logic              o_full,
  output logic              o_empty,
  output logic [LVL_W-1:0]  o_level
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/spi_frame_relay.sv
// spi_frame_relay: buffers frames from the SPI slave core in a FIFO, applies the
// selected transform and re-sends them through the SPI master core.
// Interface parameters on the bus instance must match DATA_W/DEPTH/CNT_W here.
module spi_frame_relay
  import spi_relay_pkg::*;
#(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned CNT_W        = 16,
  parameter bit          DROP_ON_FULL = 1'b1
) (
  input logic              i_clk,
  input logic              i_rst,
  spi_frame_relay_if.slave bus
);

  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_tx_inc;
  logic [DATA_W-1:0] w_head;
  logic [LVL_W-1:0]  w_level;

  rx_state_e         r_rx_state;
  rx_state_e         w_rx_state_d;
  logic              r_rx_rd;
  logic              w_rx_rd_d;

  tx_state_e         r_tx_state;
  tx_state_e         w_tx_state_d;
  logic              r_guard;
  logic              w_guard_d;
  logic              r_tx_wr;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_tx_data_d;

  logic [CNT_W-1:0]  r_rx_cnt;
  logic [CNT_W-1:0]  r_tx_cnt;
  logic [CNT_W-1:0]  r_drop_cnt;

  spi_relay_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (bus.rx_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Intake next-state: one push or one drop per frame, then hold the ack until
  // the slave core releases RX_VALID.
  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_rd_d    = r_rx_rd;
    w_push       = 1'b0;
    w_drop       = 1'b0;
    case (r_rx_state)
      RX_IDLE: begin
        if (bus.rx_valid) begin
          if (!w_full) begin
            w_push       = 1'b1;
            w_rx_rd_d    = 1'b1;
            w_rx_state_d = RX_ACK;
          end else if (DROP_ON_FULL) begin
            w_drop       = 1'b1;
            w_rx_rd_d    = 1'b1;
            w_rx_state_d = RX_ACK;
          end
        end
      end
      RX_ACK: begin
        if (!bus.rx_valid) begin
          w_rx_rd_d    = 1'b0;
          w_rx_state_d = RX_IDLE;
        end
      end
      default: begin
        w_rx_rd_d    = 1'b0;
        w_rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Intake state, acknowledge and intake counters.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rx_state <= RX_IDLE;
      r_rx_rd    <= 1'b0;
      r_rx_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      r_rx_state <= w_rx_state_d;
      r_rx_rd    <= w_rx_rd_d;
      if (w_push) r_rx_cnt   <= r_rx_cnt + CNT_W'(1);
      if (w_drop) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  // Output next-state: pop and transform in idle, one strobe cycle, then two
  // guard cycles so the master core has time to raise BUSY.
  always_comb begin
    w_tx_state_d = r_tx_state;
    w_guard_d    = r_guard;
    w_tx_data_d  = r_tx_data;
    w_pop        = 1'b0;
    w_tx_inc     = 1'b0;
    unique case (r_tx_state)
      TX_IDLE: begin
        if (bus.enable && !w_empty && !bus.tx_busy) begin
          w_pop        = 1'b1;
          // MODE is captured here, so later changes leave this frame alone.
          w_tx_data_d  = DATA_W'(transform(mode_e'(bus.mode), XFORM_W'(w_head), DATA_W));
          w_tx_state_d = TX_STROBE;
        end
      end
      TX_STROBE: begin
        w_tx_inc     = 1'b1;
        w_guard_d    = 1'b0;
        w_tx_state_d = TX_GUARD;
      end
      TX_GUARD: begin
        if (r_guard) begin
          w_tx_state_d = TX_IDLE;
        end else begin
          w_guard_d = 1'b1;
        end
      end
      default: begin
        w_guard_d    = 1'b0;
        w_tx_state_d = TX_IDLE;
      end
    endcase
  end

  // Output state, registered strobe and data, transmit counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx_state <= TX_IDLE;
      r_guard    <= 1'b0;
      r_tx_wr    <= 1'b0;
      r_tx_data  <= '0;
      r_tx_cnt   <= '0;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_guard    <= w_guard_d;
      r_tx_wr    <= (w_tx_state_d == TX_STROBE);
      r_tx_data  <= w_tx_data_d;
      if (w_tx_inc) r_tx_cnt <= r_tx_cnt + CNT_W'(1);
    end
  end

  assign bus.rx_rd    = r_rx_rd;
  assign bus.tx_wr    = r_tx_wr;
  assign bus.tx_data  = r_tx_data;
  assign bus.level    = w_level;
  assign bus.rx_cnt   = r_rx_cnt;
  assign bus.tx_cnt   = r_tx_cnt;
  assign bus.drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_spi_frame_relay.sv
// tb_spi_frame_relay: two relays (drop-on-full and stall-on-full) driven side by
// side and checked every cycle against a queue-based model of the relay rules.
module tb_spi_frame_relay;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Index 0: DROP_ON_FULL=1, index 1: DROP_ON_FULL=0
  logic [1:0]  rx_valid;
  logic [1:0]  tx_busy;
  logic [1:0]  enable;
  logic [63:0] rx_data [2];
  logic [1:0]  mode    [2];
  logic [1:0]  rx_rd;
  logic [1:0]  tx_wr;
  logic [63:0] tx_data [2];
  logic [2:0]  level   [2];
  logic [15:0] rx_cnt  [2];
  logic [15:0] tx_cnt  [2];
  logic [15:0] drop_cnt[2];

  spi_frame_relay_if #(.DATA_W(64), .DEPTH(DEPTH), .CNT_W(16)) bus_d ();
  spi_frame_relay_if #(.DATA_W(64), .DEPTH(DEPTH), .CNT_W(16)) bus_s ();

  assign bus_d.rx_valid = rx_valid[0];
  assign bus_d.rx_data  = rx_data[0];
  assign bus_d.tx_busy  = tx_busy[0];
  assign bus_d.enable   = enable[0];
  assign bus_d.mode     = mode[0];
  assign bus_s.rx_valid = rx_valid[1];
  assign bus_s.rx_data  = rx_data[1];
  assign bus_s.tx_busy  = tx_busy[1];
  assign bus_s.enable   = enable[1];
  assign bus_s.mode     = mode[1];

  assign rx_rd[0]    = bus_d.rx_rd;
  assign tx_wr[0]    = bus_d.tx_wr;
  assign tx_data[0]  = bus_d.tx_data;
  assign level[0]    = bus_d.level;
  assign rx_cnt[0]   = bus_d.rx_cnt;
  assign tx_cnt[0]   = bus_d.tx_cnt;
  assign drop_cnt[0] = bus_d.drop_cnt;
  assign rx_rd[1]    = bus_s.rx_rd;
  assign tx_wr[1]    = bus_s.tx_wr;
  assign tx_data[1]  = bus_s.tx_data;
  assign level[1]    = bus_s.level;
  assign rx_cnt[1]   = bus_s.rx_cnt;
  assign tx_cnt[1]   = bus_s.tx_cnt;
  assign drop_cnt[1] = bus_s.drop_cnt;

  spi_frame_relay #(.DATA_W(64), .DEPTH(DEPTH), .CNT_W(16), .DROP_ON_FULL(1'b1)) u_drop (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_d)
  );

  spi_frame_relay #(.DATA_W(64), .DEPTH(DEPTH), .CNT_W(16), .DROP_ON_FULL(1'b0)) u_stall (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_s)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int k, input logic [63:0] act,
                     input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] cycle %0d: actual=%h required=%h", name, k, cyc, act, exp);
    end
  endtask

  task automatic bound_fail(input string name, input int k);
    n_assert++;
    n_fail++;
    $display("FAIL %s[%0d] cycle %0d: actual=timeout required=event", name, k, cyc);
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] mq [2][$];   // frames held in the FIFO, head first
  logic        m_ack   [2];
  int          m_phase [2]; // 0 idle, 1 strobe, 2..3 guard
  logic [63:0] m_tx_data [2];
  logic [15:0] m_rx_cnt [2];
  logic [15:0] m_tx_cnt [2];
  logic [15:0] m_drop   [2];

  function automatic logic [63:0] ref_xform(input logic [1:0] m, input logic [63:0] x);
    case (m)
      2'd0:    return x;
      2'd1:    return ~x;
      2'd2:    return x + 64'd1;
      default: return {<<8{x}};
    endcase
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      m_ack[k]     = 1'b0;
      m_phase[k]   = 0;
      m_tx_data[k] = '0;
      m_rx_cnt[k]  = '0;
      m_tx_cnt[k]  = '0;
      m_drop[k]    = '0;
    end
  endfunction

  function automatic void model_step(input int k);
    bit full, empty, pop;
    full  = (mq[k].size() == DEPTH);
    empty = (mq[k].size() == 0);
    pop   = (m_phase[k] == 0) && enable[k] && !empty && !tx_busy[k];
    if (m_phase[k] == 1) m_tx_cnt[k] = m_tx_cnt[k] + 16'd1;
    if (pop) begin
      m_tx_data[k] = ref_xform(mode[k], mq[k][0]);
      void'(mq[k].pop_front());
      m_phase[k] = 1;
    end else if (m_phase[k] != 0) begin
      m_phase[k] = (m_phase[k] + 1) % 4;
    end
    if (!m_ack[k]) begin
      if (rx_valid[k]) begin
        if (!full) begin
          mq[k].push_back(rx_data[k]);
          m_ack[k]    = 1'b1;
          m_rx_cnt[k] = m_rx_cnt[k] + 16'd1;
        end else if (k == 0) begin
          m_ack[k]  = 1'b1;
          m_drop[k] = m_drop[k] + 16'd1;
        end
      end
    end else if (!rx_valid[k]) begin
      m_ack[k] = 1'b0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) model_reset();
    else for (int k = 0; k < 2; k++) model_step(k);
  end

  // Every-cycle comparison of both relays against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("rx_rd",    k, rx_rd[k],    m_ack[k]);
      chk("tx_wr",    k, tx_wr[k],    m_phase[k] == 1);
      chk("tx_data",  k, tx_data[k],  m_tx_data[k]);
      chk("level",    k, level[k],    mq[k].size());
      chk("rx_cnt",   k, rx_cnt[k],   m_rx_cnt[k]);
      chk("tx_cnt",   k, tx_cnt[k],   m_tx_cnt[k]);
      chk("drop_cnt", k, drop_cnt[k], m_drop[k]);
    end
  end

  // Transmit monitor and watchdog.
  logic [63:0] txq [2][$];
  int          txt [2][$];
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (tx_wr[k] === 1'b1) begin
        txq[k].push_back(tx_data[k]);
        txt[k].push_back(cyc);
      end
    end
    if (cyc > 60000) begin
      n_fail++;
      $display("FAIL watchdog: actual=%0d cycles required=<60000", cyc);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $fatal(1, "watchdog");
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_tx(input int k);
    txq[k].delete();
    txt[k].delete();
  endtask

  task automatic send(input int k, input logic [63:0] d, input int budget);
    int n;
    @(negedge clk);
    rx_data[k]  = d;
    rx_valid[k] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rx_rd[k] !== 1'b1 && n < budget);
    if (rx_rd[k] !== 1'b1) bound_fail("ack_wait", k);
    rx_valid[k] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rx_rd[k] !== 1'b0 && n < budget);
    if (rx_rd[k] !== 1'b0) bound_fail("ack_release", k);
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n;
    n = 0;
    while ((mq[k].size() != 0 || m_phase[k] != 0 || rx_valid[k]) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) bound_fail("idle_wait", k);
    repeat (2) @(negedge clk);
  endtask

  task automatic rand_traffic(input int k, input int nfr);
    logic [63:0] d;
    for (int i = 0; i < nfr; i++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       d = '1;
        1:       d = 64'hFF;
        default: ;
      endcase
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send(k, d, 3000);
    end
  endtask

  task automatic rand_ctrl(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        tx_busy[k] = ($urandom_range(0, 3) == 0);
        enable[k]  = ($urandom_range(0, 9) != 0);
        mode[k]    = 2'($urandom_range(0, 3));
      end
    end
    tx_busy = 2'b00;
    enable  = 2'b11;
  endtask

  logic [63:0] frames [6];
  logic [63:0] mode_in  [4] = '{64'hFF, 64'hFF, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF};
  logic [1:0]  mode_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
  logic [63:0] mode_exp [4] = '{64'hFFFF_FFFF_FFFF_FF00, 64'h0000_0000_0000_0100,
                                64'hFF00_0000_0000_0000, 64'h0};

  initial begin
    rx_valid = '0;
    tx_busy  = '0;
    enable   = '0;
    for (int k = 0; k < 2; k++) begin
      rx_data[k] = '0;
      mode[k]    = 2'd0;
    end
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and model pins
    for (int k = 0; k < 2; k++) begin
      chk("rst_rx_rd", k, rx_rd[k], 0);
      chk("rst_tx_wr", k, tx_wr[k], 0);
      chk("rst_tx_data", k, tx_data[k], 0);
      chk("rst_level", k, level[k], 0);
      chk("rst_cnts", k, {rx_cnt[k], tx_cnt[k], drop_cnt[k]}, 0);
    end
    chk("model_inc_wrap", 0, ref_xform(2'd2, 64'hFFFF_FFFF_FFFF_FFFF), 64'h0);
    chk("model_bswap", 0, ref_xform(2'd3, 64'h0123456789ABCDEF), 64'hEFCDAB8967452301);

    // Single frame, pass-through
    enable = 2'b11;
    clear_tx(0);
    send(0, 64'h0123456789ABCDEF, 50);
    wait_idle(0, 50);
    chk("single_pulses", 0, txq[0].size(), 1);
    if (txq[0].size() > 0) chk("single_data", 0, txq[0][0], 64'h0123456789ABCDEF);
    chk("single_rx_cnt", 0, rx_cnt[0], 1);
    chk("single_tx_cnt", 0, tx_cnt[0], 1);
    chk("single_level", 0, level[0], 0);

    // Transform modes
    for (int i = 0; i < 4; i++) begin
      mode[0] = mode_sel[i];
      clear_tx(0);
      send(0, mode_in[i], 50);
      wait_idle(0, 50);
      chk("mode_pulses", i, txq[0].size(), 1);
      if (txq[0].size() > 0) chk("mode_data", i, txq[0][0], mode_exp[i]);
    end
    mode[0] = 2'd0;

    // Overflow with drop policy
    enable[0] = 1'b0;
    clear_tx(0);
    for (int i = 0; i < 6; i++) begin
      frames[i] = {$urandom, $urandom};
      send(0, frames[i], 50);
    end
    chk("ovf_level", 0, level[0], 4);
    chk("ovf_drop", 0, drop_cnt[0], 2);
    enable[0] = 1'b1;
    wait_idle(0, 100);
    chk("ovf_pulses", 0, txq[0].size(), 4);
    for (int i = 0; i < 4 && i < txq[0].size(); i++) chk("ovf_order", i, txq[0][i], frames[i]);
    chk("ovf_tx_cnt", 0, tx_cnt[0], 9);

    // Overflow with stall policy
    enable[1] = 1'b0;
    mode[1]   = 2'd0;
    clear_tx(1);
    for (int i = 0; i < 5; i++) frames[i] = {$urandom, $urandom};
    fork
      for (int i = 0; i < 5; i++) send(1, frames[i], 200);
      begin
        repeat (40) @(negedge clk);
        chk("stall_valid", 1, rx_valid[1], 1);
        chk("stall_no_rd", 1, rx_rd[1], 0);
        chk("stall_level", 1, level[1], 4);
        enable[1] = 1'b1;
      end
    join
    wait_idle(1, 100);
    chk("stall_pulses", 1, txq[1].size(), 5);
    for (int i = 0; i < 5 && i < txq[1].size(); i++) chk("stall_order", i, txq[1][i], frames[i]);
    chk("stall_drop", 1, drop_cnt[1], 0);
    chk("stall_rx_cnt", 1, rx_cnt[1], 5);

    // Backpressure
    tx_busy[0] = 1'b1;
    clear_tx(0);
    for (int i = 0; i < 3; i++) send(0, 64'hA5A5_0000_0000_0000 | 64'(i), 50);
    repeat (100) @(negedge clk);
    chk("bp_no_wr", 0, txq[0].size(), 0);
    chk("bp_level", 0, level[0], 3);
    tx_busy[0] = 1'b0;
    wait_idle(0, 100);
    chk("bp_pulses", 0, txq[0].size(), 3);
    for (int i = 1; i < txt[0].size(); i++) chk("bp_spacing", i, txt[0][i] - txt[0][i-1] >= 4, 1);

    // Reset mid-handshake
    enable[0] = 1'b0;
    send(0, 64'h1111, 50);
    @(negedge clk);
    rx_data[0]  = 64'h2222;
    rx_valid[0] = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (rx_rd[0] !== 1'b1 && n < 50);
      if (rx_rd[0] !== 1'b1) bound_fail("rst_ack_wait", 0);
    end
    chk("pre_rst_level", 0, level[0], 2);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_rx_rd", 0, rx_rd[0], 0);
    chk("mid_rst_tx_wr", 0, tx_wr[0], 0);
    chk("mid_rst_level", 0, level[0], 0);
    chk("mid_rst_cnts", 0, {rx_cnt[0], tx_cnt[0], drop_cnt[0]}, 0);
    rx_valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    enable[0] = 1'b1;
    clear_tx(0);
    send(0, 64'hCAFE_F00D_DEAD_BEEF, 50);
    wait_idle(0, 50);
    chk("post_rst_pulses", 0, txq[0].size(), 1);
    if (txq[0].size() > 0) chk("post_rst_data", 0, txq[0][0], 64'hCAFE_F00D_DEAD_BEEF);
    chk("post_rst_cnt", 0, {rx_cnt[0], tx_cnt[0]}, {16'd1, 16'd1});

    // Randomised traffic on both relays
    fork
      rand_traffic(0, 60);
      rand_traffic(1, 60);
      rand_ctrl(1500);
    join
    wait_idle(0, 200);
    wait_idle(1, 200);
    chk("rand_accounting", 0, rx_cnt[0] + drop_cnt[0], m_rx_cnt[0] + m_drop[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
